regfile_dump_unit: RTL and testbench

- Debug stage downstream of the single-cycle MIPS core.
- Watches the core PC to detect program end: PC held at one value for a set number of consecutive cycles, i.e. a branch/jump-to-self.
- On detection, captures the final PC and walks the register file through a read port.
- Emits one {index, data} beat per register on a valid/ready stream, so benches and hardware log the end state without hierarchical peeking.

---
 rtl/regfile_dump_unit_pkg.sv | 26 ++
 rtl/regfile_dump_unit_halt_detector.sv | 44 ++++
 rtl/regfile_dump_unit.sv | 153 +++++++++++++++
 tb/tb_regfile_dump_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_dump_unit_pkg.sv
// mips_dbg_pkg: shared definitions for the register-file dump debug stage.
//   - default build constants (register count, widths, halt threshold)
//   - dump FSM state encoding
//   - packed dump beat {idx, data, last} at the default widths
package mips_dbg_pkg;

  localparam int unsigned DEF_NUM_REGS    = 32;
  localparam int unsigned DEF_ADDR_W      = 5;
  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_PC_W        = 32;
  localparam int unsigned DEF_HALT_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WATCH = 2'd1,
    DUMP  = 2'd2,
    DONE  = 2'd3
  } dump_state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] idx;
    logic [DEF_DATA_W-1:0] data;
    logic                  last;
  } dump_beat_t;

endpackage

// File: rtl/regfile_dump_unit_halt_detector.sv
// halt_detector: flags a branch/jump-to-self by counting consecutive clock
// edges on which the core PC is unchanged.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_watch       : counting enabled; when low the count is cleared
//   i_pc          : core PC
//   o_halt_pulse  : high in the cycle whose edge takes the count to
//                   HALT_CYCLES (combinational, one cycle wide)
module halt_detector
  import mips_dbg_pkg::*;
#(
  parameter int unsigned PC_W        = DEF_PC_W,
  parameter int unsigned HALT_CYCLES = DEF_HALT_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_watch,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_halt_pulse
);

  localparam int unsigned     CNT_W = $clog2(HALT_CYCLES + 1);
  localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(HALT_CYCLES - 1);

  logic [PC_W-1:0]  r_pc_prev;
  logic [CNT_W-1:0] r_count;
  logic             w_match;

  assign w_match      = (i_pc == r_pc_prev);
  assign o_halt_pulse = i_watch && w_match && (r_count == THR_M1);

  // pc_prev tracks the PC every cycle, so entering WATCH starts from the
  // PC seen on the arming edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_prev <= '0;
      r_count   <= '0;
    end else begin
      r_pc_prev <= i_pc;
      if (i_watch && w_match) r_count <= r_count + 1'b1;
      else                    r_count <= '0;
    end
  end

endmodule

// File: rtl/regfile_dump_unit.sv
// regfile_dump_unit: end-of-program register-file dump for the MIPS core.
// Detects a PC held constant for HALT_CYCLES edges, captures the PC, then
// streams one {index, data} beat per register over valid/ready.
//   clk, rst_n  : clock, asynchronous active-low reset
//   arm         : enables halt watching (ignored during a dump)
//   pc_in       : core PC
//   rf_raddr    : register-file read address (combinational)
//   rf_rdata    : register-file read data, same cycle as rf_raddr
//   dump_valid/dump_ready/dump_idx/dump_data/dump_last : beat stream
//   halted, done: sticky status, cleared on return to IDLE
//   pc_final    : PC captured at halt detection
module regfile_dump_unit
  import mips_dbg_pkg::*;
#(
  parameter int unsigned NUM_REGS    = DEF_NUM_REGS,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned PC_W        = DEF_PC_W,
  parameter int unsigned HALT_CYCLES = DEF_HALT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic [PC_W-1:0]   pc_in,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              halted,
  output logic              done,
  output logic [PC_W-1:0]   pc_final
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_e       r_state;
  logic [ADDR_W-1:0] r_next_idx;
  logic              r_issued_all;
  logic              r_valid;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              r_halted;
  logic              r_done;
  logic [PC_W-1:0]   r_pc_final;

  logic w_watch;
  logic w_halt;
  logic w_load;
  logic w_load_last;

  assign w_watch = (r_state == WATCH) && arm;

  halt_detector #(
    .PC_W        (PC_W),
    .HALT_CYCLES (HALT_CYCLES)
  ) u_halt_det (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_watch      (w_watch),
    .i_pc         (pc_in),
    .o_halt_pulse (w_halt)
  );

  // next_idx is held at 0 outside DUMP, so the RF already presents
  // register 0 on the halt edge and beat 0 is loaded there; this makes the
  // first beat valid in the first DUMP cycle.
  assign rf_raddr    = r_next_idx;
  assign w_load_last = (r_next_idx == LAST_IDX);

  always_comb begin
    w_load = 1'b0;
    if (!r_issued_all) begin
      case (r_state)
        WATCH:   w_load = w_halt;
        DUMP:    w_load = !r_valid || dump_ready;
        default: w_load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_next_idx   <= '0;
      r_issued_all <= 1'b0;
      r_valid      <= 1'b0;
      r_idx        <= '0;
      r_data       <= '0;
      r_last       <= 1'b0;
      r_halted     <= 1'b0;
      r_done       <= 1'b0;
      r_pc_final   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_halted     <= 1'b0;
          r_done       <= 1'b0;
          r_next_idx   <= '0;
          r_issued_all <= 1'b0;
          if (arm) r_state <= WATCH;
        end
        WATCH: begin
          if (!arm) begin
            r_state <= IDLE;
          end else if (w_halt) begin
            r_halted   <= 1'b1;
            r_pc_final <= pc_in;
            r_state    <= DUMP;
          end
        end
        DUMP: begin
          if (r_valid && dump_ready && r_last) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (!arm) begin
            r_halted <= 1'b0;
            r_done   <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Output register load; the final load sets issued_all instead of
      // wrapping next_idx.
      if (w_load) begin
        r_valid <= 1'b1;
        r_idx   <= r_next_idx;
        r_data  <= rf_rdata;
        r_last  <= w_load_last;
        if (w_load_last) r_issued_all <= 1'b1;
        else             r_next_idx   <= r_next_idx + 1'b1;
      end
    end
  end

  assign dump_valid = r_valid;
  assign dump_idx   = r_idx;
  assign dump_data  = r_data;
  assign dump_last  = r_last;
  assign halted     = r_halted;
  assign done       = r_done;
  assign pc_final   = r_pc_final;

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Directed bench for regfile_dump_unit: halt detection, full dump,
// near-miss, backpressure, reset mid-dump, arm control, HALT_CYCLES=1 build.
module tb_regfile_dump_unit;
  import mips_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm;
  logic [31:0] pc_in;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic        dump_last;
  logic        halted;
  logic        done;
  logic [31:0] pc_final;

  logic        arm_1;
  logic [31:0] pc_in_1;
  logic [4:0]  rf_raddr_1;
  logic [31:0] rf_rdata_1;
  logic        dump_valid_1;
  logic        dump_ready_1;
  logic [4:0]  dump_idx_1;
  logic [31:0] dump_data_1;
  logic        dump_last_1;
  logic        halted_1;
  logic        done_1;
  logic [31:0] pc_final_1;

  logic [31:0] rf_mem [32];

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  assign rf_rdata   = rf_mem[rf_raddr];
  assign rf_rdata_1 = rf_mem[rf_raddr_1];

  regfile_dump_unit u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .pc_in      (pc_in),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .halted     (halted),
    .done       (done),
    .pc_final   (pc_final)
  );

  regfile_dump_unit #(
    .HALT_CYCLES (1)
  ) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm_1),
    .pc_in      (pc_in_1),
    .rf_raddr   (rf_raddr_1),
    .rf_rdata   (rf_rdata_1),
    .dump_valid (dump_valid_1),
    .dump_ready (dump_ready_1),
    .dump_idx   (dump_idx_1),
    .dump_data  (dump_data_1),
    .dump_last  (dump_last_1),
    .halted     (halted_1),
    .done       (done_1),
    .pc_final   (pc_final_1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic dump_beat_t exp_beat(input int i);
    dump_beat_t b;
    b.idx  = 5'(i);
    b.data = 32'(i) * 32'h11;
    b.last = (i == 31);
    return b;
  endfunction

  task automatic chk_beat(input string tag, input int i);
    chk($sformatf("%s_valid%0d", tag, i), 64'(dump_valid), 64'd1);
    chk($sformatf("%s_beat%0d", tag, i), 64'({dump_idx, dump_data, dump_last}), 64'(exp_beat(i)));
  endtask

  // Sampling the cycle that shows beat 'from'; ready held high to the end.
  task automatic run_dump(input string tag, input int from);
    dump_ready = 1'b1;
    for (int i = from; i < 32; i++) begin
      chk_beat(tag, i);
      chk($sformatf("%s_done_early%0d", tag, i), 64'(done), 64'd0);
      step();
    end
    chk({tag, "_valid_end"}, 64'(dump_valid), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_halted_hold"}, 64'(halted), 64'd1);
  endtask

  task automatic hold_no_halt(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      step();
      chk($sformatf("%s_nohalt%0d", tag, k), 64'(halted), 64'd0);
    end
  endtask

  initial begin
    int exp_i;
    int cyc;
    int stall7;
    logic rdy;
    logic [3:0] pat;

    for (int i = 0; i < 32; i++) rf_mem[i] = 32'(i) * 32'h11;

    rst_n = 1'b0; arm = 1'b0; pc_in = '0; dump_ready = 1'b0;
    arm_1 = 1'b0; pc_in_1 = '0; dump_ready_1 = 1'b1;
    step(); step();

    // Reset state
    chk("rst_valid",    64'(dump_valid), 64'd0);
    chk("rst_idx",      64'(dump_idx),   64'd0);
    chk("rst_data",     64'(dump_data),  64'd0);
    chk("rst_last",     64'(dump_last),  64'd0);
    chk("rst_halted",   64'(halted),     64'd0);
    chk("rst_done",     64'(done),       64'd0);
    chk("rst_pcfinal",  64'(pc_final),   64'd0);
    chk("rst_raddr",    64'(rf_raddr),   64'd0);
    chk("rst1_halted",  64'(halted_1),   64'd0);
    chk("rst1_valid",   64'(dump_valid_1), 64'd0);
    rst_n = 1'b1;
    step();

    // Halt and full dump
    arm = 1'b1; dump_ready = 1'b1;
    pc_in = 32'h00; step();
    pc_in = 32'h04; step();
    chk("t1_nohalt_a", 64'(halted), 64'd0);
    pc_in = 32'h08; step();
    pc_in = 32'h20; step();
    chk("t1_nohalt_b", 64'(halted), 64'd0);
    hold_no_halt("t1", 3);
    step();
    chk("t1_halted",  64'(halted),   64'd1);
    chk("t1_pcfinal", 64'(pc_final), 64'h20);
    run_dump("t1", 0);
    arm = 1'b0; step();
    chk("t1_done_clr",   64'(done),     64'd0);
    chk("t1_halted_clr", 64'(halted),   64'd0);
    chk("t1_pcf_keep",   64'(pc_final), 64'h20);

    // Near-miss, then backpressured dump with arm dropped mid-dump
    dump_ready = 1'b0;
    arm = 1'b1; pc_in = 32'h20; step();
    hold_no_halt("t2a", 3);
    pc_in = 32'h24;
    hold_no_halt("t2b", 4);
    step();
    chk("t2_halted",  64'(halted),   64'd1);
    chk("t2_pcfinal", 64'(pc_final), 64'h24);
    arm = 1'b0;
    pat = 4'b1001;
    exp_i = 0; cyc = 0; stall7 = 0;
    while (exp_i < 32 && cyc < 200) begin
      rdy = pat[cyc % 4];
      if (exp_i == 7 && stall7 < 5) begin
        rdy = 1'b0;
        stall7++;
      end
      dump_ready = rdy;
      chk_beat("bp", exp_i);
      if (rdy) exp_i++;
      step();
      cyc++;
    end
    chk("bp_bound",      64'(cyc < 200), 64'd1);
    chk("bp_valid_end",  64'(dump_valid), 64'd0);
    chk("bp_done",       64'(done),       64'd1);
    step();
    chk("bp_done_clr",   64'(done),   64'd0);
    chk("bp_halted_clr", 64'(halted), 64'd0);

    // Reset mid-dump
    arm = 1'b1; pc_in = 32'h40; dump_ready = 1'b1; step();
    hold_no_halt("t3", 3);
    step();
    chk("t3_halted", 64'(halted), 64'd1);
    for (int i = 0; i <= 10; i++) begin
      chk_beat("t3", i);
      step();
    end
    chk_beat("t3pre", 11);
    rst_n = 1'b0; arm = 1'b0;
    #1;
    chk("t3r_valid",   64'(dump_valid), 64'd0);
    chk("t3r_idx",     64'(dump_idx),   64'd0);
    chk("t3r_data",    64'(dump_data),  64'd0);
    chk("t3r_last",    64'(dump_last),  64'd0);
    chk("t3r_halted",  64'(halted),     64'd0);
    chk("t3r_done",    64'(done),       64'd0);
    chk("t3r_pcfinal", 64'(pc_final),   64'd0);
    chk("t3r_raddr",   64'(rf_raddr),   64'd0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("t3_idle_valid", 64'(dump_valid), 64'd0);
    arm = 1'b1; step();
    hold_no_halt("t3b", 3);
    step();
    chk("t3b_halted",  64'(halted),   64'd1);
    chk("t3b_pcfinal", 64'(pc_final), 64'h40);
    run_dump("t3b", 0);
    arm = 1'b0; step();

    // arm dropped during WATCH with a stable PC clears the count
    arm = 1'b1; pc_in = 32'h50; step();
    step(); step();
    arm = 1'b0;
    hold_no_halt("t4off", 3);
    arm = 1'b1; step();
    hold_no_halt("t4on", 3);
    step();
    chk("t4_halted",  64'(halted),   64'd1);
    chk("t4_pcfinal", 64'(pc_final), 64'h50);
    run_dump("t4", 0);
    arm = 1'b0; step();
    chk("t4_done_clr", 64'(done), 64'd0);

    // HALT_CYCLES=1 build
    arm_1 = 1'b1; pc_in_1 = 32'h100; step();
    pc_in_1 = 32'h104; step();
    chk("h1_nohalt", 64'(halted_1), 64'd0);
    step();
    chk("h1_halted",  64'(halted_1),     64'd1);
    chk("h1_pcfinal", 64'(pc_final_1),   64'h104);
    chk("h1_valid",   64'(dump_valid_1), 64'd1);
    chk("h1_idx",     64'(dump_idx_1),   64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
